fft_analyze_sched: RTL and testbench

//  Buffers complete 16-bin FFT frames from the FFT core and sequences them one at a time into the

---
 rtl/fft_analyze_pkg.sv | 28 ++
 rtl/fft_analyze_sched_fifo.sv | 60 ++++++
 rtl/fft_analyze_sched.sv | 141 ++++++++++++++
 tb/tb_fft_analyze_sched.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_analyze_pkg.sv
// Shared types and constants for the FFT frame scheduler: frame geometry,
// result widths, FSM state encoding and the FIFO entry layout.
package fft_analyze_pkg;

  localparam int BINS    = 16;
  localparam int DW      = 32;
  localparam int FRAME_W = BINS * DW;
  localparam int SEQ_W   = 8;
  localparam int FREQ_W  = 4;
  localparam int ERR_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_EMIT   = 2'd3
  } state_e;

  typedef struct packed {
    logic [SEQ_W-1:0]   seq;
    logic [FRAME_W-1:0] frame;
  } fifo_entry_t;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == {ERR_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fft_analyze_sched_fifo.sv
// Frame FIFO: DEPTH entries of {sequence tag, frame}, head shown combinationally.
// Full/empty come from a registered occupancy count; no bypass when full.
module frame_fifo
  import fft_analyze_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  fifo_entry_t entry_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output fifo_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);

  fifo_entry_t     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: frame storage is deliberately not reset; the count decides which
  // entries are meaningful, and resetting wide RAM costs routing for nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/fft_analyze_sched.sv
// Queues FFT frames and hands them one at a time to the shared peak analyzer,
// returning each peak index tagged with its frame sequence number.
module fft_analyze_sched
  import fft_analyze_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FRAME_W-1:0] in_frame,
  output logic               ana_valid,
  output logic [FRAME_W-1:0] ana_frame,
  input  logic               ana_done,
  input  logic [FREQ_W-1:0]  ana_freq,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FREQ_W-1:0]  out_freq,
  output logic [SEQ_W-1:0]   out_seq,
  output logic               out_err,
  output logic [ERR_W-1:0]   err_cnt
);

  localparam int            WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [FRAME_W-1:0] ana_frame_q, ana_frame_d;
  logic [FREQ_W-1:0]  out_freq_q, out_freq_d;
  logic [SEQ_W-1:0]   out_seq_q, out_seq_d;
  logic               out_err_q, out_err_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  fifo_entry_t fifo_in, fifo_head;

  // Held low throughout reset so the producer never sees a stale ready.
  assign in_ready  = ~rst & ~fifo_full;
  assign fifo_push = in_valid & in_ready;
  assign fifo_in   = '{seq: seq_q, frame: in_frame};

  frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .entry_i (fifo_in),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    ana_frame_d = ana_frame_q;
    out_freq_d  = out_freq_q;
    out_seq_d   = out_seq_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    seq_d       = fifo_push ? seq_q + 1'b1 : seq_q;
    ana_valid   = 1'b0;
    out_valid   = 1'b0;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d     = ST_LAUNCH;
          ana_frame_d = fifo_head.frame;
        end
      end
      ST_LAUNCH: begin
        ana_valid = 1'b1;
        wd_d      = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the watchdog's last cycle still counts as success.
        if (ana_done) begin
          out_freq_d = ana_freq;
          out_err_d  = 1'b0;
          out_seq_d  = fifo_head.seq;
          state_d    = ST_EMIT;
        end else if (wd_q == WD_LAST) begin
          out_freq_d = '0;
          out_err_d  = 1'b1;
          out_seq_d  = fifo_head.seq;
          err_cnt_d  = sat_inc(err_cnt_q);
          state_d    = ST_EMIT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fifo_pop = 1'b1;
          wd_d     = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wd_q        <= '0;
      ana_frame_q <= '0;
      out_freq_q  <= '0;
      out_seq_q   <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      seq_q       <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      ana_frame_q <= ana_frame_d;
      out_freq_q  <= out_freq_d;
      out_seq_q   <= out_seq_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
      seq_q       <= seq_d;
    end
  end

  assign ana_frame = ana_frame_q;
  assign out_freq  = out_freq_q;
  assign out_seq   = out_seq_q;
  assign out_err   = out_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_fft_analyze_sched.sv
// Self-checking bench for fft_analyze_sched: random frames with a planted peak,
// a behavioural analyzer, and a scoreboard of expected tagged results.
module tb_fft_analyze_sched;
  import fft_analyze_pkg::*;

  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [FRAME_W-1:0] in_frame;
  logic               ana_valid;
  logic [FRAME_W-1:0] ana_frame;
  logic               ana_done;
  logic [FREQ_W-1:0]  ana_freq;
  logic               out_valid;
  logic               out_ready;
  logic [FREQ_W-1:0]  out_freq;
  logic [SEQ_W-1:0]   out_seq;
  logic               out_err;
  logic [ERR_W-1:0]   err_cnt;

  always #5 clk = ~clk;

  fft_analyze_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_frame  (in_frame),
    .ana_valid (ana_valid),
    .ana_frame (ana_frame),
    .ana_done  (ana_done),
    .ana_freq  (ana_freq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_freq  (out_freq),
    .out_seq   (out_seq),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    int         seq;
    logic [3:0] freq;
    logic       err;
    int         lat;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [FRAME_W-1:0] acc_frames[$];
  int                 acc_seq[$];
  exp_t               exp_q[$];
  int                 acc_cnt    = 0;
  int                 acc_cyc    = 0;
  int                 launch_cyc = 0;
  int                 n_launch   = 0;
  int                 n_out      = 0;
  int                 tb_err     = 0;
  bit                 ana_en     = 1'b1;
  int                 ana_delay  = 15;
  bit                 rand_delay = 1'b0;
  bit                 saw_wrap   = 1'b0;
  logic [3:0]         last_freq  = '0;
  logic [7:0]         last_seq   = '0;
  logic               last_err   = 1'b0;

  always @(posedge clk) cyc++;

  function automatic logic [FRAME_W-1:0] make_frame(input int peak);
    logic [FRAME_W-1:0] f;
    logic [15:0]        re, im;
    for (int k = 0; k < BINS; k++) begin
      re = 16'($urandom_range(400)) - 16'd200;
      im = 16'($urandom_range(400)) - 16'd200;
      if (k == peak) re = ($urandom_range(1) != 0) ? 16'd20000 : 16'hB1E0;
      f[k*DW +: DW] = {re, im};
    end
    return f;
  endfunction

  // Peak bin = largest re^2 + im^2 over the frame.
  function automatic int peak_of(input logic [FRAME_W-1:0] f);
    int                 best = 0;
    longint             bm   = -1;
    longint             m;
    logic signed [15:0] re, im;
    for (int k = 0; k < BINS; k++) begin
      re = f[k*DW+16 +: 16];
      im = f[k*DW +: 16];
      m  = longint'(re) * re + longint'(im) * im;
      if (m > bm) begin
        bm   = m;
        best = k;
      end
    end
    return best;
  endfunction

  // Analyzer model: checks the presented frame, predicts the result, answers after a delay.
  initial begin
    ana_done = 1'b0;
    ana_freq = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && ana_valid) begin
        exp_t               e;
        logic [FRAME_W-1:0] fr;
        logic [FRAME_W-1:0] want;
        int                 d;
        bit                 abort;
        fr = ana_frame;
        n_launch++;
        launch_cyc = cyc;
        n_cmp++;
        if (acc_frames.size() == 0) begin
          n_bad++;
          $display("FAIL launch_order: ana_valid with no accepted frame outstanding");
          e.seq = -1;
        end else begin
          want  = acc_frames.pop_front();
          e.seq = acc_seq.pop_front();
          if (fr !== want) begin
            n_bad++;
            $display("FAIL ana_frame: got %0h required %0h", fr[63:0], want[63:0]);
          end
        end
        d     = rand_delay ? int'($urandom_range(25, 1)) : ana_delay;
        e.err = !(ana_en && d <= TIMEOUT);
        e.freq = e.err ? 4'd0 : 4'(peak_of(fr));
        e.lat  = e.err ? TIMEOUT + 1 : d + 1;
        exp_q.push_back(e);
        if (ana_en) begin
          abort = 1'b0;
          for (int i = 0; i < d; i++) begin
            @(negedge clk);
            #1;
            if (rst) begin
              abort = 1'b1;
              break;
            end
            n_cmp++;
            if (ana_frame !== fr || ana_valid !== 1'b0) begin
              n_bad++;
              $display("FAIL ana_hold: got valid=%0b frame=%0h required valid=0 frame=%0h",
                       ana_valid, ana_frame[63:0], fr[63:0]);
            end
          end
          if (!abort) begin
            ana_freq = 4'(peak_of(fr));
            ana_done = 1'b1;
            @(negedge clk);
            #1;
            ana_done = 1'b0;
            ana_freq = 4'($urandom);
          end
        end
      end
    end
  end

  // Result monitor: rise latency, hold stability under backpressure, scoreboard order.
  initial begin
    bit         prev_v;
    logic [3:0] pf;
    logic [7:0] ps;
    logic       pe;
    exp_t       e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid && !prev_v && exp_q.size() > 0) begin
          n_cmp++;
          if (cyc - launch_cyc !== exp_q[0].lat) begin
            n_bad++;
            $display("FAIL result_latency: got %0d required %0d", cyc - launch_cyc, exp_q[0].lat);
          end
        end
        if (out_valid && prev_v) begin
          n_cmp++;
          if ({out_freq, out_seq, out_err} !== {pf, ps, pe}) begin
            n_bad++;
            $display("FAIL out_hold: got %0h/%0h/%0b required %0h/%0h/%0b",
                     out_freq, out_seq, out_err, pf, ps, pe);
          end
        end
        if (out_valid && out_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_result: got seq=%0d required none", out_seq);
          end else begin
            e = exp_q.pop_front();
            if ({out_freq, out_seq, out_err} !== {e.freq, 8'(e.seq), e.err}) begin
              n_bad++;
              $display("FAIL result: got freq=%0d seq=%0d err=%0b required freq=%0d seq=%0d err=%0b",
                       out_freq, out_seq, out_err, e.freq, e.seq % 256, e.err);
            end
            if (e.err && tb_err < 255) tb_err++;
          end
          if (out_seq == 8'd0 && last_seq == 8'd255) saw_wrap = 1'b1;
          last_freq = out_freq;
          last_seq  = out_seq;
          last_err  = out_err;
          n_out++;
        end
        prev_v = out_valid && !out_ready;
        pf     = out_freq;
        ps     = out_seq;
        pe     = out_err;
      end
    end
  end

  // Presents one frame (call at a falling edge) and returns once it has been accepted.
  task automatic push_frame(input int peak);
    logic [FRAME_W-1:0] f;
    int                 guard;
    f        = make_frame(peak);
    guard    = 0;
    in_frame = f;
    in_valid = 1'b1;
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: got in_ready=0 for %0d cycles required acceptance", guard);
      in_valid = 1'b0;
      return;
    end
    acc_frames.push_back(f);
    acc_seq.push_back(acc_cnt % 256);
    acc_cnt++;
    acc_cyc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic wait_results(input int target);
    int guard = 0;
    while (n_out < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (n_out < target) begin
      n_bad++;
      $display("FAIL wait_results: got %0d results required %0d", n_out, target);
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++;
    if ({in_ready, ana_valid, out_valid, out_freq, out_seq, out_err, err_cnt} !== '0) begin
      n_bad++;
      $display("FAIL %s: got rdy=%0b av=%0b ov=%0b freq=%0h seq=%0h err=%0b cnt=%0h required all 0",
               tag, in_ready, ana_valid, out_valid, out_freq, out_seq, out_err, err_cnt);
    end
    n_cmp++;
    if (ana_frame !== '0) begin
      n_bad++;
      $display("FAIL %s_frame: got %0h required 0", tag, ana_frame[63:0]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_frame = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset: got rdy=%0b ov=%0b required rdy=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_single();
    int n0 = n_out;
    int l0 = n_launch;
    ana_en = 1'b1; ana_delay = 15;
    push_frame(5);
    in_valid = 1'b0;
    wait_results(n0 + 1);
    n_cmp++;
    if (n_launch - l0 !== 1) begin
      n_bad++;
      $display("FAIL single_pulses: got %0d required 1", n_launch - l0);
    end
    n_cmp++;
    if (launch_cyc !== acc_cyc + 1) begin
      n_bad++;
      $display("FAIL launch_latency: got cycle %0d required %0d", launch_cyc, acc_cyc + 1);
    end
    n_cmp++;
    if ({last_freq, last_seq, last_err} !== {4'd5, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL single_result: got freq=%0d seq=%0d err=%0b required 5/0/0",
               last_freq, last_seq, last_err);
    end
  endtask

  task automatic test_back_to_back();
    int n0 = n_out;
    push_frame(3);
    push_frame(9);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_full: got in_ready=%0b required 0", in_ready);
    end
    push_frame(12);
    in_valid = 1'b0;
    wait_results(n0 + 3);
    n_cmp++;
    if (last_freq !== 4'd12) begin
      n_bad++;
      $display("FAIL b2b_last: got freq=%0d required 12", last_freq);
    end
  endtask

  task automatic test_timeout();
    int n0 = n_out;
    ana_en = 1'b0;
    push_frame(7);
    in_valid = 1'b0;
    wait_results(n0 + 1);
    n_cmp++;
    if ({last_err, last_freq, err_cnt} !== {1'b1, 4'd0, 8'd1}) begin
      n_bad++;
      $display("FAIL timeout: got err=%0b freq=%0d cnt=%0d required 1/0/1", last_err, last_freq, err_cnt);
    end
    // done on the watchdog's final cycle, then one cycle too late
    ana_en = 1'b1; ana_delay = TIMEOUT;
    push_frame(11);
    in_valid = 1'b0;
    wait_results(n0 + 2);
    ana_delay = TIMEOUT + 1;
    push_frame(2);
    in_valid = 1'b0;
    wait_results(n0 + 3);
    ana_delay = 15;
    push_frame(4);
    in_valid = 1'b0;
    wait_results(n0 + 4);
    n_cmp++;
    if ({last_err, last_freq} !== {1'b0, 4'd4} || int'(err_cnt) !== tb_err) begin
      n_bad++;
      $display("FAIL after_timeout: got err=%0b freq=%0d cnt=%0d required 0/4/%0d",
               last_err, last_freq, err_cnt, tb_err);
    end
  endtask

  task automatic test_backpressure();
    int n0 = n_out;
    int l0 = n_launch;
    int guard = 0;
    out_ready = 1'b0; ana_delay = 10;
    push_frame(1);
    push_frame(6);
    in_valid = 1'b0;
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b10 || n_launch - l0 !== 1) begin
      n_bad++;
      $display("FAIL backpressure: got ov=%0b rdy=%0b launches=%0d required 1/0/1",
               out_valid, in_ready, n_launch - l0);
    end
    out_ready = 1'b1;
    wait_results(n0 + 2);
  endtask

  task automatic test_reset_mid();
    int n0;
    int l0 = n_launch;
    int guard = 0;
    ana_delay = 20;
    push_frame(8);
    push_frame(13);
    in_valid = 1'b0;
    while (n_launch == l0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("mid_reset");
    repeat (2) @(negedge clk);
    acc_frames.delete(); acc_seq.delete(); exp_q.delete();
    acc_cnt = 0; tb_err = 0;
    rst = 1'b0;
    n0 = n_out;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || n_out !== n0) begin
      n_bad++;
      $display("FAIL stale_result: got ov=%0b results=%0d required 0/%0d", out_valid, n_out, n0);
    end
    ana_delay = 15;
    push_frame(10);
    in_valid = 1'b0;
    wait_results(n0 + 1);
    n_cmp++;
    if ({last_seq, last_freq} !== {8'd0, 4'd10}) begin
      n_bad++;
      $display("FAIL post_reset_seq: got seq=%0d freq=%0d required 0/10", last_seq, last_freq);
    end
  endtask

  task automatic test_wrap();
    int n0 = n_out;
    bit stop = 1'b0;
    rand_delay = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) push_frame(int'($urandom_range(BINS - 1)));
        in_valid = 1'b0;
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(negedge clk);
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_results(n0 + 300);
    rand_delay = 1'b0;
    n_cmp++;
    if (saw_wrap !== 1'b1 || int'(last_seq) !== (acc_cnt - 1) % 256) begin
      n_bad++;
      $display("FAIL seq_wrap: got wrap=%0b last=%0d required 1/%0d", saw_wrap, last_seq, (acc_cnt - 1) % 256);
    end
    // Spurious done with nothing in flight.
    n0 = n_out;
    repeat (5) begin
      @(negedge clk);
      ana_done = 1'b1;
      ana_freq = 4'($urandom);
    end
    @(negedge clk);
    ana_done = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || n_out !== n0) begin
      n_bad++;
      $display("FAIL spurious_done: got ov=%0b results=%0d required 0/%0d", out_valid, n_out, n0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
